uart_crc_receiver: RTL and testbench

Receive end of the UART CRC-8 link. Deserialises two consecutive 8N1 characters from tx_out: a data byte followed by its CRC byte, both LSB first. Recomputes CRC-8 over the data byte and reports the byte pair with a pass/fail flag. It sits between the board RX pin and the user/debug logic, as the counterpart of uart_transmitter.

---
 rtl/uart_crc_pkg.sv | 35 +++
 rtl/uart_rx_sync.sv | 22 ++
 rtl/uart_crc_receiver.sv | 162 ++++++++++++++++
 tb/tb_uart_crc_receiver.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_crc_pkg.sv
// Shared constants, state encoding and CRC-8 helper for the UART CRC link.
// The transmitter and receiver both import this package.
package uart_crc_pkg;

    localparam logic [7:0] CRC8_POLY            = 8'h07;
    localparam logic [7:0] CRC8_INIT            = 8'h00;
    localparam int         CLKS_PER_BIT_DEF     = 434;
    localparam int         GAP_TIMEOUT_BITS_DEF = 20;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_GAP       = 3'd4,
        ST_WAIT_HIGH = 3'd5
    } rx_state_t;

    // MSB-first CRC-8, no reflection, no final XOR.
    function automatic logic [7:0] crc8(input logic [7:0] data,
                                        input logic [7:0] poly,
                                        input logic [7:0] init);
        logic [7:0] c;
        c = init ^ data;
        for (int i = 0; i < 8; i++) begin
            if (c[7]) begin
                c = {c[6:0], 1'b0} ^ poly;
            end else begin
                c = {c[6:0], 1'b0};
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous RX pin; resets to the idle-high level.
module uart_rx_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic i_async,
    output logic o_sync
);

    logic [1:0] r_sync;

    // Shift the raw pin through two flops to settle metastability.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], i_async};
        end
    end

    assign o_sync = r_sync[1];

endmodule

// File: rtl/uart_crc_receiver.sv
// Receives an 8N1 data byte followed by its CRC-8 byte and reports the pair
// with a CRC pass/fail flag, plus framing and inter-byte timeout pulses.
module uart_crc_receiver
    import uart_crc_pkg::*;
#(
    parameter int         CLKS_PER_BIT     = CLKS_PER_BIT_DEF,
    parameter logic [7:0] CRC_POLY         = CRC8_POLY,
    parameter logic [7:0] CRC_INIT         = CRC8_INIT,
    parameter int         GAP_TIMEOUT_BITS = GAP_TIMEOUT_BITS_DEF
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx_in,
    output logic [7:0] data_out,
    output logic [7:0] crc_out,
    output logic       data_valid,
    output logic       crc_error,
    output logic       framing_error,
    output logic       timeout_error,
    output logic       rx_busy
);

    localparam int CNT_W     = $clog2(CLKS_PER_BIT);
    localparam int GAP_LIMIT = GAP_TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int GAP_W     = $clog2(GAP_LIMIT + 1);

    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [GAP_W-1:0] GAP_M1  = GAP_W'(GAP_LIMIT - 1);

    logic             w_rx_s;
    logic [7:0]       w_crc_calc;
    rx_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [GAP_W-1:0] r_gap_cnt;
    logic [2:0]       r_bit_idx;
    logic             r_byte_sel;
    logic [7:0]       r_shift;
    logic [7:0]       r_data_byte;

    uart_rx_sync u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .i_async (rx_in),
        .o_sync  (w_rx_s)
    );

    assign w_crc_calc = crc8(r_data_byte, CRC_POLY, CRC_INIT);

    // Receive FSM; every output is a register updated here.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_gap_cnt     <= '0;
            r_bit_idx     <= 3'd0;
            r_byte_sel    <= 1'b0;
            r_shift       <= 8'h00;
            r_data_byte   <= 8'h00;
            data_out      <= 8'h00;
            crc_out       <= 8'h00;
            data_valid    <= 1'b0;
            crc_error     <= 1'b0;
            framing_error <= 1'b0;
            timeout_error <= 1'b0;
            rx_busy       <= 1'b0;
        end else begin
            data_valid    <= 1'b0;
            framing_error <= 1'b0;
            timeout_error <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!w_rx_s) begin
                        rx_busy    <= 1'b1;
                        r_byte_sel <= 1'b0;
                        r_cnt      <= '0;
                        r_state    <= ST_START;
                    end
                end
                ST_START: begin
                    if (r_cnt == HALF_M1) begin
                        r_cnt <= '0;
                        if (!w_rx_s) begin
                            r_bit_idx <= 3'd0;
                            r_state   <= ST_DATA;
                        end else if (r_byte_sel) begin
                            // A glitch while waiting for the CRC byte keeps the pair alive.
                            r_gap_cnt <= '0;
                            r_state   <= ST_GAP;
                        end else begin
                            rx_busy <= 1'b0;
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (r_cnt == FULL_M1) begin
                        r_cnt     <= '0;
                        r_shift   <= {w_rx_s, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= ST_STOP;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    if (r_cnt == FULL_M1) begin
                        r_cnt <= '0;
                        if (!w_rx_s) begin
                            framing_error <= 1'b1;
                            rx_busy       <= 1'b0;
                            r_state       <= ST_WAIT_HIGH;
                        end else if (!r_byte_sel) begin
                            r_data_byte <= r_shift;
                            r_gap_cnt   <= '0;
                            r_state     <= ST_GAP;
                        end else begin
                            data_out   <= r_data_byte;
                            crc_out    <= r_shift;
                            crc_error  <= (w_crc_calc != r_shift);
                            data_valid <= 1'b1;
                            rx_busy    <= 1'b0;
                            r_state    <= ST_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    if (!w_rx_s) begin
                        r_byte_sel <= 1'b1;
                        r_cnt      <= '0;
                        r_gap_cnt  <= '0;
                        r_state    <= ST_START;
                    end else if (r_gap_cnt == GAP_M1) begin
                        timeout_error <= 1'b1;
                        rx_busy       <= 1'b0;
                        r_gap_cnt     <= '0;
                        r_state       <= ST_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + GAP_W'(1);
                    end
                end
                ST_WAIT_HIGH: begin
                    // Line held low (break): wait for idle before hunting for a start bit.
                    if (w_rx_s) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    rx_busy <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_crc_receiver.sv
// Self-checking bench for uart_crc_receiver: table of byte pairs through a
// scoreboard, plus hand-written framing, timeout, glitch and reset sequences.
module tb_uart_crc_receiver;

    localparam int CPB = 16;

    typedef struct packed {
        logic [7:0] d;
        logic [7:0] c;
        logic       e;
    } frame_t;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx_in   = 1'b1;
    logic [7:0] data_out;
    logic [7:0] crc_out;
    logic       data_valid;
    logic       crc_error;
    logic       framing_error;
    logic       timeout_error;
    logic       rx_busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int dv_cnt = 0, fe_cnt = 0, to_cnt = 0, to_cyc = 0, multi_cnt = 0;
    frame_t exp_q[$];
    frame_t obs_q[$];
    frame_t vecs[7];

    uart_crc_receiver #(.CLKS_PER_BIT(CPB)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .rx_in         (rx_in),
        .data_out      (data_out),
        .crc_out       (crc_out),
        .data_valid    (data_valid),
        .crc_error     (crc_error),
        .framing_error (framing_error),
        .timeout_error (timeout_error),
        .rx_busy       (rx_busy)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (data_valid) begin
            dv_cnt <= dv_cnt + 1;
            obs_q.push_back('{data_out, crc_out, crc_error});
        end
        if (framing_error) fe_cnt <= fe_cnt + 1;
        if (timeout_error) begin
            to_cnt <= to_cnt + 1;
            to_cyc <= cyc;
        end
        if ((32'(data_valid) + 32'(framing_error) + 32'(timeout_error)) > 32'd1)
            multi_cnt <= multi_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic bit_out(input logic b);
        rx_in = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop);
        bit_out(1'b0);
        for (int i = 0; i < 8; i++) bit_out(d[i]);
        bit_out(stop);
    endtask

    task automatic send_pair(input logic [7:0] d, input logic [7:0] c, input logic e);
        exp_q.push_back('{d, c, e});
        send_byte(d, 1'b1);
        send_byte(c, 1'b1);
    endtask

    task automatic expect_frame(input string name);
        frame_t ex, ob;
        int n;
        n = 0;
        while (obs_q.size() == 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        ex = exp_q.pop_front();
        if (obs_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s_valid: no data_valid within 200 cycles, want data %0h", name, ex.d);
        end else begin
            ob = obs_q.pop_front();
            check({name, "_data"}, 32'(ob.d), 32'(ex.d));
            check({name, "_crc"},  32'(ob.c), 32'(ex.c));
            check({name, "_err"},  32'(ob.e), 32'(ex.e));
        end
    endtask

    initial begin
        int dv0, fe0, to0, t0, rel;
        logic seen;

        vecs[0] = '{8'h55, 8'hAC, 1'b0};
        vecs[1] = '{8'h55, 8'hA3, 1'b1};
        vecs[2] = '{8'hFF, 8'h00, 1'b1};
        vecs[3] = '{8'hFF, 8'hF3, 1'b0};
        vecs[4] = '{8'h00, 8'h00, 1'b0};
        vecs[5] = '{8'h01, 8'h07, 1'b0};
        vecs[6] = '{8'h80, 8'h89, 1'b0};

        #50;
        check("reset_outputs", {data_out, crc_out, data_valid, crc_error,
                                framing_error, timeout_error, rx_busy}, 32'd0);
        #50;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (2 * CPB) @(posedge clk);
        #1;

        for (int i = 0; i < 7; i++) begin
            send_pair(vecs[i].d, vecs[i].c, vecs[i].e);
            expect_frame($sformatf("vec%0d", i));
        end

        // Data byte with a low stop bit, then a 30-bit break.
        dv0 = dv_cnt;
        fe0 = fe_cnt;
        send_byte(8'hAB, 1'b0);
        repeat (30 * CPB) @(posedge clk);
        #1;
        check("framing_pulse", 32'(fe_cnt - fe0), 32'd1);
        check("framing_no_valid", 32'(dv_cnt - dv0), 32'd0);
        check("framing_data_hold", 32'(data_out), 32'h80);
        check("framing_crc_hold", 32'(crc_out), 32'h89);
        check("framing_busy", 32'(rx_busy), 32'd0);
        rx_in = 1'b1;
        repeat (2 * CPB) @(posedge clk);
        #1;
        send_pair(8'h55, 8'hAC, 1'b0);
        expect_frame("after_break");

        // Timeout: 3 cycles to detect, 8 to mid-start, 8x16 data, 16 stop, 320 gap.
        dv0 = dv_cnt;
        to0 = to_cnt;
        t0  = cyc;
        send_byte(8'h12, 1'b1);
        repeat (21) bit_out(1'b1);
        check("timeout_pulse", 32'(to_cnt - to0), 32'd1);
        check("timeout_cycle", 32'(to_cyc - t0), 32'd475);
        check("timeout_busy", 32'(rx_busy), 32'd0);
        check("timeout_no_valid", 32'(dv_cnt - dv0), 32'd0);
        check("timeout_data_hold", 32'(data_out), 32'h55);

        // Four-cycle low glitch on an idle line.
        dv0  = dv_cnt;
        fe0  = fe_cnt;
        to0  = to_cnt;
        seen = 1'b0;
        rel  = 0;
        rx_in = 1'b0;
        for (int n = 1; n <= 30; n++) begin
            @(posedge clk);
            #1;
            if (n == 4) rx_in = 1'b1;
            if (rx_busy) seen = 1'b1;
            else if (seen && rel == 0) rel = n;
        end
        check("glitch_busy_seen", 32'(seen), 32'd1);
        check("glitch_busy_release", 32'(rel > 0 && rel <= CPB / 2 + 3), 32'd1);
        check("glitch_no_pulses", 32'((dv_cnt - dv0) + (fe_cnt - fe0) + (to_cnt - to0)), 32'd0);

        // Reset during the CRC byte's data bits.
        dv0 = dv_cnt;
        send_byte(8'h55, 1'b1);
        bit_out(1'b0);
        bit_out(1'b0);
        bit_out(1'b1);
        check("midframe_busy", 32'(rx_busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check("midframe_reset_outputs", {data_out, crc_out, data_valid, crc_error,
                                         framing_error, timeout_error, rx_busy}, 32'd0);
        rx_in = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (2 * CPB) @(posedge clk);
        #1;
        check("midframe_no_valid", 32'(dv_cnt - dv0), 32'd0);
        send_pair(8'h55, 8'hAC, 1'b0);
        expect_frame("after_reset");

        repeat (4) @(posedge clk);
        #1;
        check("pulse_exclusive", 32'(multi_cnt), 32'd0);
        check("frame_count", 32'(dv_cnt), 32'd9);
        check("scoreboard_empty", 32'(exp_q.size() + obs_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
